// File: rtl/regfile_mp.sv
// Multi-port register file with per-register busy scoreboard for RAW hazard detection.
// Supports combinational or registered reads, optional write bypass and a hardwired-zero x0.
module regfile_mp #(
  parameter int XLEN      = 32,
  parameter int DEPTH     = 32,
  parameter int NREAD     = 2,
  parameter int NWRITE    = 1,
  parameter int SYNC_READ = 0,
  parameter int BYPASS    = 1,
  parameter int ZERO_REG  = 1,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREAD-1:0]        rd_en,
  input  logic [NREAD*AW-1:0]     rd_addr,
  output logic [NREAD*XLEN-1:0]   rd_data,
  output logic [NREAD-1:0]        rd_busy,
  input  logic [NWRITE-1:0]       wr_en,
  input  logic [NWRITE*AW-1:0]    wr_addr,
  input  logic [NWRITE*XLEN-1:0]  wr_data,
  input  logic                    rsv_en,
  input  logic [AW-1:0]           rsv_addr
);

  logic [XLEN-1:0]  regs_q [DEPTH];
  logic [XLEN-1:0]  regs_d [DEPTH];
  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;

  logic [NREAD*XLEN-1:0] rdata_c;
  logic [NREAD-1:0]      rbusy_c;

  // Out-of-range and (optionally) zero-register addresses never hold state.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (int'(a) < DEPTH) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  // Next-state array: ascending port order lets the highest write port win,
  // and the reservation is applied last so it overrides a same-cycle clear.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    for (int j = 0; j < NWRITE; j++) begin
      if (wr_en[j] && addr_ok(wr_addr[j*AW +: AW])) begin
        regs_d[wr_addr[j*AW +: AW]] = wr_data[j*XLEN +: XLEN];
        busy_d[wr_addr[j*AW +: AW]] = 1'b0;
      end
    end
    if (rsv_en && addr_ok(rsv_addr)) begin
      busy_d[rsv_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        regs_q[k] <= '0;
      end
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  // Bypass reads the post-edge view (regs_d/busy_d); otherwise the stored array.
  always_comb begin
    rdata_c = '0;
    rbusy_c = '0;
    for (int i = 0; i < NREAD; i++) begin
      if (addr_ok(rd_addr[i*AW +: AW])) begin
        if (BYPASS != 0) begin
          rdata_c[i*XLEN +: XLEN] = regs_d[rd_addr[i*AW +: AW]];
          rbusy_c[i]              = busy_d[rd_addr[i*AW +: AW]];
        end else begin
          rdata_c[i*XLEN +: XLEN] = regs_q[rd_addr[i*AW +: AW]];
          rbusy_c[i]              = busy_q[rd_addr[i*AW +: AW]];
        end
      end
    end
  end

  generate
    if (SYNC_READ != 0) begin : g_sync_rd
      logic [NREAD*XLEN-1:0] rd_data_q;
      logic [NREAD-1:0]      rd_busy_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rd_data_q <= '0;
          rd_busy_q <= '0;
        end else begin
          for (int i = 0; i < NREAD; i++) begin
            if (rd_en[i]) begin
              rd_data_q[i*XLEN +: XLEN] <= rdata_c[i*XLEN +: XLEN];
              rd_busy_q[i]              <= rbusy_c[i];
            end
          end
        end
      end

      assign rd_data = rd_data_q;
      assign rd_busy = rd_busy_q;
    end else begin : g_async_rd
      logic unused_rd_en;
      assign unused_rd_en = ^rd_en;
      assign rd_data      = rdata_c;
      assign rd_busy      = rbusy_c;
    end
  endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: async no-bypass, async bypass with two write ports,
// and registered-read with non-power-of-two depth.
module tb_regfile_mp;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Instance A: SYNC_READ=0, BYPASS=0, NWRITE=1
  logic [1:0]  a_rd_en;
  logic [9:0]  a_rd_addr;
  logic [63:0] a_rd_data;
  logic [1:0]  a_rd_busy;
  logic        a_wr_en;
  logic [4:0]  a_wr_addr;
  logic [31:0] a_wr_data;
  logic        a_rsv_en;
  logic [4:0]  a_rsv_addr;

  regfile_mp #(.NWRITE(1), .SYNC_READ(0), .BYPASS(0)) u_a (
    .clk(clk), .rst(rst), .rd_en(a_rd_en), .rd_addr(a_rd_addr),
    .rd_data(a_rd_data), .rd_busy(a_rd_busy), .wr_en(a_wr_en),
    .wr_addr(a_wr_addr), .wr_data(a_wr_data), .rsv_en(a_rsv_en),
    .rsv_addr(a_rsv_addr)
  );

  // Instance B: SYNC_READ=0, BYPASS=1, NWRITE=2
  logic [1:0]  b_rd_en;
  logic [9:0]  b_rd_addr;
  logic [63:0] b_rd_data;
  logic [1:0]  b_rd_busy;
  logic [1:0]  b_wr_en;
  logic [9:0]  b_wr_addr;
  logic [63:0] b_wr_data;
  logic        b_rsv_en;
  logic [4:0]  b_rsv_addr;

  regfile_mp #(.NWRITE(2), .SYNC_READ(0), .BYPASS(1)) u_b (
    .clk(clk), .rst(rst), .rd_en(b_rd_en), .rd_addr(b_rd_addr),
    .rd_data(b_rd_data), .rd_busy(b_rd_busy), .wr_en(b_wr_en),
    .wr_addr(b_wr_addr), .wr_data(b_wr_data), .rsv_en(b_rsv_en),
    .rsv_addr(b_rsv_addr)
  );

  // Instance C: SYNC_READ=1, BYPASS=0, DEPTH=20, one read port
  logic        c_rd_en;
  logic [4:0]  c_rd_addr;
  logic [31:0] c_rd_data;
  logic        c_rd_busy;
  logic        c_wr_en;
  logic [4:0]  c_wr_addr;
  logic [31:0] c_wr_data;
  logic        c_rsv_en;
  logic [4:0]  c_rsv_addr;

  regfile_mp #(.DEPTH(20), .NREAD(1), .NWRITE(1), .SYNC_READ(1), .BYPASS(0)) u_c (
    .clk(clk), .rst(rst), .rd_en(c_rd_en), .rd_addr(c_rd_addr),
    .rd_data(c_rd_data), .rd_busy(c_rd_busy), .wr_en(c_wr_en),
    .wr_addr(c_wr_addr), .wr_data(c_wr_data), .rsv_en(c_rsv_en),
    .rsv_addr(c_rsv_addr)
  );

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic        rsv;
    logic [4:0]  ra;
    logic [4:0]  r0;
    logic [4:0]  r1;
    logic [31:0] e0;
    logic        eb0;
    logic [31:0] e1;
    logic        eb1;
  } vec_t;

  vec_t va[12];
  vec_t vb[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_all();
    a_wr_en = 1'b0; a_wr_addr = '0; a_wr_data = '0; a_rsv_en = 1'b0; a_rsv_addr = '0;
    b_wr_en = '0;   b_wr_addr = '0; b_wr_data = '0; b_rsv_en = 1'b0; b_rsv_addr = '0;
    c_wr_en = 1'b0; c_wr_addr = '0; c_wr_data = '0; c_rsv_en = 1'b0; c_rsv_addr = '0;
    a_rd_en = '0; a_rd_addr = '0; b_rd_en = '0; b_rd_addr = '0; c_rd_en = 1'b0; c_rd_addr = '0;
  endtask

  task automatic apply_a(input vec_t v, input int idx);
    @(negedge clk);
    a_wr_en = v.we[0]; a_wr_addr = v.wa0; a_wr_data = v.wd0;
    a_rsv_en = v.rsv; a_rsv_addr = v.ra;
    a_rd_addr = {v.r1, v.r0};
    #1;
    chk($sformatf("A[%0d] rd_data0", idx), a_rd_data[31:0], v.e0);
    chk($sformatf("A[%0d] rd_busy0", idx), {31'd0, a_rd_busy[0]}, {31'd0, v.eb0});
    chk($sformatf("A[%0d] rd_data1", idx), a_rd_data[63:32], v.e1);
    chk($sformatf("A[%0d] rd_busy1", idx), {31'd0, a_rd_busy[1]}, {31'd0, v.eb1});
  endtask

  task automatic apply_b(input vec_t v, input int idx);
    @(negedge clk);
    b_wr_en = v.we; b_wr_addr = {v.wa1, v.wa0}; b_wr_data = {v.wd1, v.wd0};
    b_rsv_en = v.rsv; b_rsv_addr = v.ra;
    b_rd_addr = {v.r1, v.r0};
    #1;
    chk($sformatf("B[%0d] rd_data0", idx), b_rd_data[31:0], v.e0);
    chk($sformatf("B[%0d] rd_busy0", idx), {31'd0, b_rd_busy[0]}, {31'd0, v.eb0});
    chk($sformatf("B[%0d] rd_data1", idx), b_rd_data[63:32], v.e1);
    chk($sformatf("B[%0d] rd_busy1", idx), {31'd0, b_rd_busy[1]}, {31'd0, v.eb1});
  endtask

  task automatic c_cyc(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic rsv, input logic [4:0] ra, input logic ren,
                       input logic [4:0] raddr, input logic [31:0] exp_d,
                       input logic exp_b, input string name);
    @(negedge clk);
    c_wr_en = we; c_wr_addr = wa; c_wr_data = wd;
    c_rsv_en = rsv; c_rsv_addr = ra; c_rd_en = ren; c_rd_addr = raddr;
    @(posedge clk);
    #1;
    chk({name, " rd_data"}, c_rd_data, exp_d);
    chk({name, " rd_busy"}, {31'd0, c_rd_busy}, {31'd0, exp_b});
  endtask

  initial begin
    //        we     wa0    wd0           wa1    wd1     rsv   ra     r0     r1     e0            eb0   e1            eb1
    va[0]  = '{2'b01, 5'd3, 32'h1234,     5'd0, 32'h0,  1'b0, 5'd0, 5'd3, 5'd3, 32'h0,        1'b0, 32'h0,        1'b0};
    va[1]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  1'b0, 5'd0, 5'd3, 5'd0, 32'h1234,     1'b0, 32'h0,        1'b0};
    va[2]  = '{2'b01, 5'd7, 32'hA5A5A5A5, 5'd0, 32'h0,  1'b0, 5'd0, 5'd7, 5'd3, 32'h0,        1'b0, 32'h1234,     1'b0};
    va[3]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  1'b0, 5'd0, 5'd7, 5'd7, 32'hA5A5A5A5, 1'b0, 32'hA5A5A5A5, 1'b0};
    va[4]  = '{2'b01, 5'd0, 32'hFFFFFFFF, 5'd0, 32'h0,  1'b1, 5'd0, 5'd0, 5'd3, 32'h0,        1'b0, 32'h1234,     1'b0};
    va[5]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  1'b0, 5'd0, 5'd0, 5'd7, 32'h0,        1'b0, 32'hA5A5A5A5, 1'b0};
    va[6]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  1'b1, 5'd4, 5'd4, 5'd4, 32'h0,        1'b0, 32'h0,        1'b0};
    va[7]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  1'b0, 5'd0, 5'd4, 5'd3, 32'h0,        1'b1, 32'h1234,     1'b0};
    va[8]  = '{2'b01, 5'd4, 32'h44,       5'd0, 32'h0,  1'b0, 5'd0, 5'd4, 5'd4, 32'h0,        1'b1, 32'h0,        1'b1};
    va[9]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  1'b0, 5'd0, 5'd4, 5'd7, 32'h44,       1'b0, 32'hA5A5A5A5, 1'b0};
    va[10] = '{2'b01, 5'd4, 32'h55,       5'd0, 32'h0,  1'b1, 5'd4, 5'd4, 5'd4, 32'h44,       1'b0, 32'h44,       1'b0};
    va[11] = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  1'b0, 5'd0, 5'd4, 5'd3, 32'h55,       1'b1, 32'h1234,     1'b0};

    vb[0]  = '{2'b01, 5'd7, 32'hA5A5A5A5, 5'd0, 32'h0,  1'b0, 5'd0, 5'd7, 5'd0, 32'hA5A5A5A5, 1'b0, 32'h0,        1'b0};
    vb[1]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  1'b0, 5'd0, 5'd7, 5'd7, 32'hA5A5A5A5, 1'b0, 32'hA5A5A5A5, 1'b0};
    vb[2]  = '{2'b11, 5'd9, 32'h11,       5'd9, 32'h22, 1'b0, 5'd0, 5'd9, 5'd7, 32'h22,       1'b0, 32'hA5A5A5A5, 1'b0};
    vb[3]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  1'b0, 5'd0, 5'd9, 5'd9, 32'h22,       1'b0, 32'h22,       1'b0};
    vb[4]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  1'b1, 5'd4, 5'd4, 5'd9, 32'h0,        1'b1, 32'h22,       1'b0};
    vb[5]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  1'b0, 5'd0, 5'd4, 5'd4, 32'h0,        1'b1, 32'h0,        1'b1};
    vb[6]  = '{2'b01, 5'd4, 32'h44,       5'd0, 32'h0,  1'b0, 5'd0, 5'd4, 5'd9, 32'h44,       1'b0, 32'h22,       1'b0};
    vb[7]  = '{2'b10, 5'd0, 32'h0,        5'd4, 32'h55, 1'b1, 5'd4, 5'd4, 5'd4, 32'h55,       1'b1, 32'h55,       1'b1};
    vb[8]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  1'b0, 5'd0, 5'd4, 5'd7, 32'h55,       1'b1, 32'hA5A5A5A5, 1'b0};
    vb[9]  = '{2'b01, 5'd0, 32'hFFFFFFFF, 5'd0, 32'h0,  1'b1, 5'd0, 5'd0, 5'd9, 32'h0,        1'b0, 32'h22,       1'b0};
    vb[10] = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  1'b0, 5'd0, 5'd0, 5'd4, 32'h0,        1'b0, 32'h55,       1'b1};
    vb[11] = '{2'b11, 5'd12, 32'h1,       5'd13, 32'h2, 1'b0, 5'd0, 5'd12, 5'd13, 32'h1,      1'b0, 32'h2,        1'b0};

    idle_all();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset C rd_data", c_rd_data, 32'h0);
    chk("reset C rd_busy", {31'd0, c_rd_busy}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Asynchronous reset mid-cycle on instance A
    @(negedge clk);
    a_wr_en = 1'b1; a_wr_addr = 5'd5; a_wr_data = 32'hDEADBEEF;
    a_rsv_en = 1'b1; a_rsv_addr = 5'd5;
    @(negedge clk);
    idle_all();
    a_rd_addr = {5'd5, 5'd5};
    #1;
    chk("pre-rst reg5 data", a_rd_data[31:0], 32'hDEADBEEF);
    chk("pre-rst reg5 busy", {31'd0, a_rd_busy[0]}, 32'h1);
    #1 rst = 1'b1;
    #1;
    chk("async rst reg5 data", a_rd_data[31:0], 32'h0);
    chk("async rst reg5 busy", {31'd0, a_rd_busy[0]}, 32'h0);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post-rst reg5 data", a_rd_data[31:0], 32'h0);

    for (int i = 0; i < 12; i++) apply_a(va[i], i);
    @(negedge clk);
    idle_all();
    for (int i = 0; i < 12; i++) apply_b(vb[i], i);
    @(negedge clk);
    idle_all();

    // Registered reads: read-before-write, capture, hold, scoreboard, out-of-range
    c_cyc(1'b1, 5'd2,  32'h55, 1'b0, 5'd0,  1'b1, 5'd2,  32'h0,  1'b0, "C rbw reg2");
    c_cyc(1'b0, 5'd0,  32'h0,  1'b0, 5'd0,  1'b1, 5'd2,  32'h55, 1'b0, "C read reg2");
    c_cyc(1'b0, 5'd0,  32'h0,  1'b0, 5'd0,  1'b0, 5'd3,  32'h55, 1'b0, "C hold");
    c_cyc(1'b0, 5'd0,  32'h0,  1'b1, 5'd6,  1'b1, 5'd6,  32'h0,  1'b0, "C rsv same edge");
    c_cyc(1'b0, 5'd0,  32'h0,  1'b0, 5'd0,  1'b1, 5'd6,  32'h0,  1'b1, "C rsv next");
    c_cyc(1'b1, 5'd25, 32'h99, 1'b1, 5'd25, 1'b1, 5'd2,  32'h55, 1'b0, "C oob write");
    c_cyc(1'b0, 5'd0,  32'h0,  1'b0, 5'd0,  1'b1, 5'd25, 32'h0,  1'b0, "C oob read");
    c_cyc(1'b0, 5'd0,  32'h0,  1'b0, 5'd0,  1'b1, 5'd9,  32'h0,  1'b0, "C no alias");
    c_cyc(1'b1, 5'd19, 32'h77, 1'b0, 5'd0,  1'b0, 5'd19, 32'h0,  1'b0, "C top write");
    c_cyc(1'b0, 5'd0,  32'h0,  1'b0, 5'd0,  1'b1, 5'd19, 32'h77, 1'b0, "C top read");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port register file; successor to the single-write, two-read async register file.
- Configurable depth, data width, read/write port counts and read mode (async/registered), with optional write-to-read bypass and hardwired-zero x0.
- Adds a per-register busy scoreboard (reserve at issue, clear at writeback) so decode can detect RAW hazards.
- Sits between decode (read ports, reserve) and writeback (write ports).

Parameters:
- XLEN, 32, data width in bits.
- DEPTH, 32, number of registers (>=2); AW = $clog2(DEPTH).
- NREAD, 2, number of read ports (>=1).
- NWRITE, 1, number of write ports (>=1).
- SYNC_READ, 0, 0 = combinational read; 1 = registered read, 1-cycle latency.
- BYPASS, 1, 1 = same-cycle write data/busy forwarded to reads.
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes and reservations.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- rd_en  in  NREAD  per-port read enable; SYNC_READ=1 only, ignored otherwise.
- rd_addr  in  NREAD*AW  read addresses, port i at [i*AW +: AW].
- rd_data  out  NREAD*XLEN  read data, port i at [i*XLEN +: XLEN].
- rd_busy  out  NREAD  busy flag of addressed register.
- wr_en  in  NWRITE  per-port write enable.
- wr_addr  in  NWRITE*AW  write addresses.
- wr_data  in  NWRITE*XLEN  write data.
- rsv_en  in  1  reserve (mark busy) register rsv_addr.
- rsv_addr  in  AW  register to reserve.

Behaviour:
- Reset (async, immediate): all registers = 0, all busy bits = 0, registered rd_data/rd_busy = 0. Reset mid-operation discards in-flight writes and reservations; the first edge after deassertion operates normally.
- Write: on posedge, reg[wr_addr[j]] <= wr_data[j] for each j with wr_en[j]=1.
- Write conflicts: several ports writing the same address in one cycle resolve to the highest j. The same rule applies to the bypass value.
- Address range: addresses >= DEPTH (non-power-of-2 DEPTH) are ignored for writes and reservations. Reads of them return data 0, busy 0.
- ZERO_REG=1: address 0 reads data 0, busy 0. Writes and rsv_en to address 0 have no effect.
- Busy update on posedge:
  - busy[a] cleared if any wr_en targets a.
  - busy[rsv_addr] set if rsv_en.
  - Reserve and write to the same register in the same cycle: busy ends set (reserve wins; the write still updates data).
- Read, SYNC_READ=0: rd_data[i] / rd_busy[i] are combinational from the current array.
- Read, SYNC_READ=1: on posedge with rd_en[i]=1, rd_data[i] / rd_busy[i] capture the values defined below. With rd_en[i]=0 they hold.
- BYPASS=1: read data is the post-edge register value, i.e. the winning wr_data if written this cycle, else stored data. rd_busy is the post-edge busy value, e.g. write-only this cycle gives busy 0; reserve this cycle gives busy 1.
- BYPASS=0: reads see the pre-edge array. In SYNC_READ=1 this is read-before-write.
- Latency: write-to-read visibility is 0 cycles with BYPASS=1, 1 cycle with BYPASS=0 (async). SYNC_READ adds 1 cycle to read output.
- Read ports are independent; any number may address the same register.

Test Plan:
- Reset: write reg5=0xDEADBEEF, reserve reg5, assert rst mid-cycle -> rd_data of reg5 = 0 and rd_busy = 0 immediately, without a clock edge.
- Basic/x0 (async, BYPASS=0): write reg3=0x1234 -> read reg3 returns 0x1234 next cycle. Write reg0=0xFFFFFFFF -> reading reg0 still 0.
- Bypass: BYPASS=1, write reg7=0xA5A5A5A5 while port0 reads reg7 in the same cycle -> rd_data0 = 0xA5A5A5A5 that cycle. With BYPASS=0, the old value 0 is returned.
- Multi-write conflict: NWRITE=2, both ports write reg9 (0x11 on port0, 0x22 on port1) -> reg9 = 0x22. The bypass read also shows 0x22.
- Scoreboard: rsv reg4 -> rd_busy=1 from next cycle. Write reg4 -> busy 0 after the edge (0 same cycle with BYPASS=1). Reserve and write reg4 in the same cycle -> busy stays 1, data updated.
- SYNC_READ=1: rd_en=1, addr reg2 (=0x55) -> rd_data=0x55 after one edge. Then rd_en=0 with addr changed -> output holds 0x55.
